// File: rtl/apf_csr_slv_if.sv
// apf_csr_slv_if -- AXI-lite bus bundle for the APF CSR responder.
//
// Handshake rule for every channel (AW, W, B, AR, R): a beat transfers on a
// rising clk edge where both valid and ready are high. The sender keeps valid
// and the payload stable until that edge; ready may depend on state only.
//
// Parameter:
//   ADDR_W  address width (must match the ADDR_W of the attached responder)
// Modports:
//   slave   responder side (apf_csr_slv)
//   master  requester side (bench or interconnect)
interface apf_csr_slv_if #(
    parameter int ADDR_W = 20
);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [63:0]       wdata;
    logic [7:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [63:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/apf_csr_slv.sv
// apf_csr_slv -- AXI-lite CSR responder for an APF function.
//
// Register map (decoded from addr[4:3] only when addr[ADDR_W-1:5] == 0):
//   0x00 DFH     RO  returns DFH_VAL
//   0x08 SCRATCH RW
//   0x10 CTRL    RW  drives ctrl_o
//   0x18 STATUS  RO  returns status_i, sampled on the AR handshake
// Unmapped reads return 0. Writes are byte-granular per wstrb; writes to RO
// or unmapped addresses are dropped but still answered.
//
// Build option: define APF_CSR_SLVERR_EN to answer unmapped accesses and RO
// writes with SLVERR (2'b10); otherwise every response is OKAY.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   bus             AXI-lite slave modport (see apf_csr_slv_if)
//   ctrl_o          CTRL register contents
//   status_i        live status value
//   dbg_w_state_o   write FSM state (W_IDLE=0, W_ADDR_HELD=1, W_DATA_HELD=2, W_RESP=3)
//   dbg_r_state_o   read FSM state (R_IDLE=0, R_RESP=1)
module apf_csr_slv #(
    parameter int          ADDR_W  = 20,
    parameter logic [63:0] DFH_VAL = 64'h3000_0000_0000_1000
) (
    input  logic               clk,
    input  logic               rst,
    apf_csr_slv_if.slave       bus,
    output logic [63:0]        ctrl_o,
    input  logic [63:0]        status_i,
    output logic [1:0]         dbg_w_state_o,
    output logic               dbg_r_state_o
);
`ifdef APF_CSR_SLVERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] IDX_DFH     = 2'd0;
    localparam logic [1:0] IDX_SCRATCH = 2'd1;
    localparam logic [1:0] IDX_CTRL    = 2'd2;
    localparam logic [1:0] IDX_STATUS  = 2'd3;

    typedef enum logic [1:0] {W_IDLE, W_ADDR_HELD, W_DATA_HELD, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_RESP} r_state_e;

    w_state_e          w_state_q, w_state_d;
    r_state_e          r_state_q, r_state_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic [63:0]       w_data_q, w_data_d;
    logic [7:0]        w_strb_q, w_strb_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [63:0]       scratch_q, scratch_d;
    logic [63:0]       ctrl_q, ctrl_d;
    logic [63:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    // Write selected this cycle (the second half of the AW/W pair arrived).
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [63:0]       wr_data;
    logic [7:0]        wr_strb;
    logic              wr_hit;
    logic [1:0]        wr_idx;
    logic              rd_hit;
    logic [1:0]        rd_idx;
    logic [63:0]       rd_val;

    function automatic logic [63:0] byte_merge(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  strb);
        logic [63:0] res;
        for (int i = 0; i < 8; i++) begin
            res[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return res;
    endfunction

    // Ready/valid are pure functions of FSM state.
    assign bus.awready   = (w_state_q == W_IDLE) || (w_state_q == W_DATA_HELD);
    assign bus.wready    = (w_state_q == W_IDLE) || (w_state_q == W_ADDR_HELD);
    assign bus.bvalid    = (w_state_q == W_RESP);
    assign bus.bresp     = bresp_q;
    assign bus.arready   = (r_state_q == R_IDLE);
    assign bus.rvalid    = (r_state_q == R_RESP);
    assign bus.rdata     = rdata_q;
    assign bus.rresp     = rresp_q;
    assign ctrl_o        = ctrl_q;
    assign dbg_w_state_o = w_state_q;
    assign dbg_r_state_o = r_state_q;

    // Write FSM: a held half is combined with the arriving half so the update
    // happens on the very edge the pair completes.
    always_comb begin
        w_state_d = w_state_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        wr_en     = 1'b0;
        wr_addr   = aw_addr_q;
        wr_data   = w_data_q;
        wr_strb   = w_strb_q;
        case (w_state_q)
            W_IDLE: begin
                if (bus.awvalid && bus.wvalid) begin
                    wr_en     = 1'b1;
                    wr_addr   = bus.awaddr;
                    wr_data   = bus.wdata;
                    wr_strb   = bus.wstrb;
                    w_state_d = W_RESP;
                end else if (bus.awvalid) begin
                    aw_addr_d = bus.awaddr;
                    w_state_d = W_ADDR_HELD;
                end else if (bus.wvalid) begin
                    w_data_d  = bus.wdata;
                    w_strb_d  = bus.wstrb;
                    w_state_d = W_DATA_HELD;
                end
            end
            W_ADDR_HELD: begin
                if (bus.wvalid) begin
                    wr_en     = 1'b1;
                    wr_data   = bus.wdata;
                    wr_strb   = bus.wstrb;
                    w_state_d = W_RESP;
                end
            end
            W_DATA_HELD: begin
                if (bus.awvalid) begin
                    wr_en     = 1'b1;
                    wr_addr   = bus.awaddr;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bus.bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Register update and write response.
    always_comb begin
        wr_hit    = (wr_addr[ADDR_W-1:5] == '0);
        wr_idx    = wr_addr[4:3];
        scratch_d = scratch_q;
        ctrl_d    = ctrl_q;
        bresp_d   = bresp_q;
        if (wr_en) begin
            if (wr_hit && wr_idx == IDX_SCRATCH) begin
                scratch_d = byte_merge(scratch_q, wr_data, wr_strb);
            end
            if (wr_hit && wr_idx == IDX_CTRL) begin
                ctrl_d = byte_merge(ctrl_q, wr_data, wr_strb);
            end
            if (ERR_EN && (!wr_hit || wr_idx == IDX_DFH || wr_idx == IDX_STATUS)) begin
                bresp_d = RESP_SLVERR;
            end else begin
                bresp_d = RESP_OKAY;
            end
        end
    end

    // Read path: data is captured from the current (pre-write) register
    // values, so a same-cycle write is not visible to this read.
    always_comb begin
        rd_hit    = (bus.araddr[ADDR_W-1:5] == '0);
        rd_idx    = bus.araddr[4:3];
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rd_val    = 64'h0;
        if (rd_hit) begin
            case (rd_idx)
                IDX_DFH:     rd_val = DFH_VAL;
                IDX_SCRATCH: rd_val = scratch_q;
                IDX_CTRL:    rd_val = ctrl_q;
                default:     rd_val = status_i;
            endcase
        end
        case (r_state_q)
            R_IDLE: begin
                if (bus.arvalid) begin
                    rdata_d   = rd_val;
                    rresp_d   = (ERR_EN && !rd_hit) ? RESP_SLVERR : RESP_OKAY;
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (bus.rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
            scratch_q <= '0;
            ctrl_q    <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bresp_q   <= bresp_d;
            scratch_q <= scratch_d;
            ctrl_q    <= ctrl_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Protection bits and the byte offset within a register are don't-care.
    logic unused_ok;
    assign unused_ok = ^{bus.awprot, bus.arprot, wr_addr[2:0], bus.araddr[2:0]};
endmodule

// File: tb/tb_apf_csr_slv.sv
module tb_apf_csr_slv;
    localparam int          ADDR_W  = 20;
    localparam logic [63:0] DFH_VAL = 64'h3000_0000_0000_1000;
`ifdef APF_CSR_SLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] ctrl_o;
    logic [63:0] status_i;
    logic [1:0]  dbg_w_state;
    logic        dbg_r_state;

    apf_csr_slv_if #(.ADDR_W(ADDR_W)) bus ();

    apf_csr_slv #(.ADDR_W(ADDR_W), .DFH_VAL(DFH_VAL)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .ctrl_o        (ctrl_o),
        .status_i      (status_i),
        .dbg_w_state_o (dbg_w_state),
        .dbg_r_state_o (dbg_r_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] m_scratch;
    logic [63:0] m_ctrl;
    logic [65:0] exp_r_q[$];   // {rresp, rdata}
    logic [1:0]  exp_b_q[$];
    logic [ADDR_W-1:0] addr_tab[6];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic mapped(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:5] == '0;
    endfunction

    function automatic logic [63:0] model_read(input logic [ADDR_W-1:0] a);
        if (!mapped(a)) return 64'h0;
        case (a[4:3])
            2'd0:    return DFH_VAL;
            2'd1:    return m_scratch;
            2'd2:    return m_ctrl;
            default: return status_i;
        endcase
    endfunction

    function automatic logic [1:0] model_rresp(input logic [ADDR_W-1:0] a);
        return (ERR_EN && !mapped(a)) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [1:0] model_bresp(input logic [ADDR_W-1:0] a);
        return (ERR_EN && (!mapped(a) || a[4:3] == 2'd0 || a[4:3] == 2'd3)) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [63:0] apply_strb(input logic [63:0] old_v, input logic [63:0] d,
                                               input logic [7:0] s);
        logic [63:0] mask;
        for (int i = 0; i < 8; i++) mask[i*8 +: 8] = {8{s[i]}};
        return (old_v & ~mask) | (d & mask);
    endfunction

    task automatic model_write(input logic [ADDR_W-1:0] a, input logic [63:0] d, input logic [7:0] s);
        if (mapped(a) && a[4:3] == 2'd1) m_scratch = apply_strb(m_scratch, d, s);
        if (mapped(a) && a[4:3] == 2'd2) m_ctrl    = apply_strb(m_ctrl, d, s);
    endtask

    // ---------------- drivers ----------------
    task automatic send_aw(input logic [ADDR_W-1:0] a);
        int n = 0;
        bus.awaddr  = a;
        bus.awprot  = 3'($urandom_range(0, 7));
        bus.awvalid = 1'b1;
        while (!bus.awready && n < 50) begin step(); n++; end
        if (n >= 50) check("aw_accept_timeout", bus.awready, 1);
        step();
        bus.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] d, input logic [7:0] s);
        int n = 0;
        bus.wdata  = d;
        bus.wstrb  = s;
        bus.wvalid = 1'b1;
        while (!bus.wready && n < 50) begin step(); n++; end
        if (n >= 50) check("w_accept_timeout", bus.wready, 1);
        step();
        bus.wvalid = 1'b0;
    endtask

    task automatic collect_b(input int hold);
        int         n = 0;
        logic [1:0] first;
        while (!bus.bvalid && n < 50) begin step(); n++; end
        check("b_valid", bus.bvalid, 1);
        if (exp_b_q.size() == 0) check("b_unexpected", bus.bvalid, 0);
        else check("bresp", bus.bresp, exp_b_q.pop_front());
        check("ctrl_o_after_wr", ctrl_o, m_ctrl);
        first = bus.bresp;
        repeat (hold) begin
            step();
            check("b_hold_valid", bus.bvalid, 1);
            check("b_hold_resp", bus.bresp, first);
            check("b_hold_awready", bus.awready, 0);
            check("b_hold_wready", bus.wready, 0);
        end
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        check("b_drop", bus.bvalid, 0);
    endtask

    // aw_dly / w_dly: cycles before presenting each half (0/0 = same cycle).
    task automatic axi_write(input logic [ADDR_W-1:0] a, input logic [63:0] d, input logic [7:0] s,
                             input int aw_dly, input int w_dly, input int hold);
        exp_b_q.push_back(model_bresp(a));
        fork
            begin repeat (aw_dly) step(); send_aw(a); end
            begin repeat (w_dly) step(); send_w(d, s); end
        join
        model_write(a, d, s);
        collect_b(hold);
    endtask

    task automatic axi_read(input logic [ADDR_W-1:0] a, input int hold, input string tag);
        int          n = 0;
        logic [65:0] exp;
        logic [65:0] first;
        bus.araddr  = a;
        bus.arprot  = 3'($urandom_range(0, 7));
        bus.arvalid = 1'b1;
        while (!bus.arready && n < 50) begin step(); n++; end
        if (n >= 50) check("ar_accept_timeout", bus.arready, 1);
        exp_r_q.push_back({model_rresp(a), model_read(a)});
        step();
        bus.arvalid = 1'b0;
        status_i    = ~status_i;   // a later change must not leak into rdata
        check({tag, "_latency"}, bus.rvalid, 1);
        if (exp_r_q.size() == 0) check("r_unexpected", bus.rvalid, 0);
        else begin
            exp = exp_r_q.pop_front();
            check({tag, "_rdata"}, bus.rdata, exp[63:0]);
            check({tag, "_rresp"}, bus.rresp, exp[65:64]);
        end
        first = {bus.rresp, bus.rdata};
        repeat (hold) begin
            step();
            check("r_hold_valid", bus.rvalid, 1);
            check("r_hold_payload", bus.rdata, first[63:0]);
            check("r_hold_rresp", bus.rresp, first[65:64]);
            check("r_hold_arready", bus.arready, 0);
        end
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
        check("r_drop", bus.rvalid, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0;  bus.wstrb = '0;  bus.wvalid = 1'b0;  bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        status_i  = {$urandom, $urandom};
        m_scratch = '0;
        m_ctrl    = '0;
        addr_tab  = '{20'h00, 20'h08, 20'h10, 20'h18, 20'h20, 20'h108};

        #1 rst = 1'b1;
        #2;
        check("rst_awready", bus.awready, 1);
        check("rst_wready", bus.wready, 1);
        check("rst_arready", bus.arready, 1);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_bresp", bus.bresp, 0);
        check("rst_rresp", bus.rresp, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_ctrl_o", ctrl_o, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();

        // DFH read straight out of reset.
        axi_read(20'h00, 0, "dfh");

        // AW two cycles ahead of W; exactly one response.
        axi_write(20'h08, 64'hDEAD_BEEF_0123_4567, 8'hFF, 0, 2, 0);
        repeat (3) begin step(); check("b_once", bus.bvalid, 0); end
        axi_read(20'h08, 0, "scratch");

        // Partial strobe over CTRL = 0.
        axi_write(20'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, 0, 0);
        check("ctrl_o_low_half", ctrl_o, 64'h0000_0000_FFFF_FFFF);

        // Back-pressure on both response channels, W ahead of AW.
        axi_write(20'h08, 64'h1122_3344_5566_7788, 8'hFF, 2, 0, 5);
        axi_read(20'h08, 5, "scratch_bp");

        // wstrb = 0 still answers and leaves CTRL alone.
        axi_write(20'h10, 64'h0123_4567_89AB_CDEF, 8'h00, 0, 0, 0);
        axi_read(20'h10, 0, "ctrl_strb0");

        // Writes to RO and unmapped addresses are dropped.
        axi_write(20'h00, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 0, 0, 0);
        axi_write(20'h18, 64'hBBBB_BBBB_BBBB_BBBB, 8'hFF, 0, 1, 0);
        axi_write(20'h20, 64'hCCCC_CCCC_CCCC_CCCC, 8'hFF, 1, 0, 0);
        axi_write(20'h108, 64'hDDDD_DDDD_DDDD_DDDD, 8'hFF, 0, 0, 0);
        axi_read(20'h00, 0, "dfh_after_ro_wr");
        status_i = {$urandom, $urandom};
        axi_read(20'h18, 1, "status");
        axi_read(20'h08, 0, "scratch_after_unmapped_wr");

        // Unmapped reads.
        axi_read(20'h20, 0, "unmapped_20");
        axi_read(20'h108, 0, "unmapped_high");

        // Same-cycle read and write of SCRATCH returns the old value.
        fork
            axi_write(20'h08, 64'hCAFE_F00D_0000_0001, 8'hFF, 0, 0, 0);
            axi_read(20'h08, 0, "rw_same_cycle");
        join
        axi_read(20'h08, 0, "scratch_after_same");

        // Random mix.
        for (int i = 0; i < 30; i++) begin
            logic [ADDR_W-1:0] a;
            a = addr_tab[$urandom_range(0, 5)];
            if ($urandom_range(0, 1) == 1) begin
                axi_write(a, {$urandom, $urandom}, 8'($urandom_range(0, 255)),
                          $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
            end else begin
                status_i = {$urandom, $urandom};
                axi_read(a, $urandom_range(0, 2), "rand_rd");
            end
        end

        // Reset while an AW is held.
        bus.awaddr  = 20'h08;
        bus.awvalid = 1'b1;
        step();
        bus.awvalid = 1'b0;
        check("addr_held_state", dbg_w_state, 1);
        check("addr_held_awready", bus.awready, 0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_awready", bus.awready, 1);
        check("async_rst_wready", bus.wready, 1);
        check("async_rst_ctrl_o", ctrl_o, 0);
        m_scratch = '0;
        m_ctrl    = '0;
        exp_b_q.delete();
        exp_r_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) begin
            step();
            check("post_rst_bvalid", bus.bvalid, 0);
            check("post_rst_awready", bus.awready, 1);
        end
        axi_read(20'h08, 0, "scratch_after_rst");
        axi_read(20'h10, 0, "ctrl_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/apf_csr_slv.md
APF_CSR_SLV -- requirements
Module: apf_csr_slv

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_W, 20, AXI-lite address width.
- DFH_VAL, 64'h3000_0000_0000_1000, value returned by the DFH register.
REQ-002 Ports (name direction width meaning), one per line:
- clk  in  1  sole clock.
- rst  in  1  reset; asynchronous, active-high.
- awaddr  in  ADDR_W  write address.
- awprot  in  3  ignored.
- awvalid  in  1, awready  out  1  write-address handshake.
- wdata  in  64, wstrb  in  8  write data and byte strobes.
- wvalid  in  1, wready  out  1  write-data handshake.
- bresp  out  2, bvalid  out  1, bready  in  1  write response.
- araddr  in  ADDR_W  read address.
- arprot  in  3  ignored.
- arvalid  in  1, arready  out  1  read-address handshake.
- rdata  out  64, rresp  out  2, rvalid  out  1, rready  in  1  read response.
- ctrl_o  out  64  CTRL register contents.
- status_i  in  64  live status, read-only view.

Function
REQ-003 The block SHALL act as an AXI-lite responder for APF functions; it SHALL decode address bits [4:3] only when bits [ADDR_W-1:5] are zero:
- 0x00 DFH: RO.
- 0x08 SCRATCH: RW.
- 0x10 CTRL: RW, drives ctrl_o.
- 0x18 STATUS: RO, returns status_i.
REQ-004 Write FSM states SHALL be W_IDLE, W_ADDR_HELD, W_DATA_HELD, W_RESP.
REQ-005 awready SHALL be high in W_IDLE and W_DATA_HELD.
REQ-006 wready SHALL be high in W_IDLE and W_ADDR_HELD.
REQ-007 AW and W SHALL be accepted in either order or in the same cycle. The state after an accept:
- AW only: W_ADDR_HELD.
- W only: W_DATA_HELD.
- Both held: the register update and the move to W_RESP SHALL occur on the cycle the second of the pair is accepted.
REQ-008 Write update SHALL be byte-granular per wstrb. wstrb=0 SHALL leave the register unchanged and still respond.
REQ-009 Writes to DFH, STATUS or unmapped addresses SHALL have no effect.
REQ-010 bvalid SHALL assert the cycle after the update and hold, with bresp stable, until bvalid&&bready; the FSM SHALL then return to W_IDLE.
REQ-011 Read FSM states SHALL be R_IDLE and R_RESP. arready SHALL be high only in R_IDLE.
REQ-012 On arvalid&&arready, rdata and rresp SHALL be registered and rvalid SHALL assert next cycle (latency 1). rdata/rresp SHALL hold until rvalid&&rready, then the FSM returns to R_IDLE.
REQ-013 A read and a write to the same register in the same cycle SHALL return the pre-write value.
REQ-014 STATUS SHALL be sampled on the AR handshake cycle.
REQ-015 Read data for unmapped addresses SHALL be 64'h0.

Reset
REQ-016 rst SHALL asynchronously force the following, from assertion until the first clk edge after release:
- Write FSM to W_IDLE, read FSM to R_IDLE.
- awready=wready=arready=1, bvalid=rvalid=0.
- bresp=rresp=2'b00, rdata=0.
- SCRATCH=0, CTRL=0, ctrl_o=0.
REQ-017 rst mid-transaction SHALL discard held AW/W and pending responses; no response SHALL be issued for them.

Configuration
REQ-018 Macro APF_CSR_SLVERR_EN:
- Defined: accesses to unmapped addresses, and writes to RO registers, SHALL return SLVERR (2'b10) on bresp/rresp.
- Undefined: all responses SHALL be OKAY (2'b00).
- Register side effects SHALL be identical in both builds.

Verification
REQ-019 Reset then read 0x00 -> rvalid one cycle after AR handshake, rdata=DFH_VAL, rresp=OKAY.
REQ-020 Write 0x08 data 64'hDEAD_BEEF_0123_4567 with AW two cycles before W, then read 0x08 -> bvalid once, read returns the written value.
REQ-021 Write 0x10 wstrb=8'h0F data 64'hFFFF_FFFF_FFFF_FFFF over CTRL=0 -> ctrl_o=64'h0000_0000_FFFF_FFFF the cycle after the update.
REQ-022 Hold bready=0 and rready=0 for 5 cycles -> bvalid/rvalid and payloads stable; awready=wready=0 and arready=0 until the handshake.
REQ-023 Read 0x20 with and without APF_CSR_SLVERR_EN -> rdata=0, rresp=2'b10 and 2'b00 respectively.
REQ-024 Assert rst while in W_ADDR_HELD -> no bvalid afterwards, SCRATCH=0, awready=1 after release.
